// File: rtl/stage_phase_accumulator.sv
// Per-operator phase accumulator feeding the sine waveform stage.
// Three-stage pipeline: RAM read, accumulate/key-on, modulation add.

`ifndef VOICE_OPERATOR_ID
`define VOICE_OPERATOR_ID [7:0]
`endif
`ifndef ALGORITHM_WORD
`define ALGORITHM_WORD [2:0]
`endif

module stage_phase_accumulator #(
    parameter int NUM_VOICE_OPERATORS = 256,
    parameter int ACC_WIDTH           = 24
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic `VOICE_OPERATOR_ID     i_VoiceOperator,
    input  logic `ALGORITHM_WORD        i_AlgorithmWord,
    input  logic                        i_NoteOn,
    input  logic signed [16:0]          i_ModulationPhase,
    input  logic                        i_PhaseStepWriteEnable,
    input  logic `VOICE_OPERATOR_ID     i_PhaseStepWriteAddr,
    input  logic [ACC_WIDTH-1:0]        i_PhaseStepWriteData,
    output logic `VOICE_OPERATOR_ID     o_VoiceOperator,
    output logic `ALGORITHM_WORD        o_AlgorithmWord,
    output logic                        o_NoteOn,
    output logic signed [16:0]          o_Phase,
    output logic                        o_Ready
);

    localparam int PHASE_W = 16;

    typedef logic `VOICE_OPERATOR_ID opId_t;
    typedef logic `ALGORITHM_WORD    alg_t;
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam opId_t LAST_ID = opId_t'(NUM_VOICE_OPERATORS - 1);

    logic [ACC_WIDTH-1:0] accRam  [NUM_VOICE_OPERATORS];
    logic [ACC_WIDTH-1:0] stepRam [NUM_VOICE_OPERATORS];
    logic                 histRam [NUM_VOICE_OPERATORS];

    state_t state_q, state_d;
    opId_t  clearCount_q, clearCount_d;
    logic   clearing;
    logic   clearWrite;
    logic   ready;

    logic                 s1Valid_q, s1Valid_d;
    opId_t                s1Id_q, s1Id_d;
    alg_t                 s1Alg_q, s1Alg_d;
    logic                 s1NoteOn_q, s1NoteOn_d;
    logic [16:0]          s1Mod_q, s1Mod_d;
    logic [ACC_WIDTH-1:0] s1Acc_q;
    logic [ACC_WIDTH-1:0] s1Step_q;
    logic                 s1Hist_q;

    logic                 keyOn;
    logic [ACC_WIDTH-1:0] accSum;
    logic [ACC_WIDTH-1:0] accWrData;
    logic [PHASE_W-1:0]   oldPhase;

    logic                 s2Valid_q;
    opId_t                s2Id_q;
    alg_t                 s2Alg_q;
    logic                 s2NoteOn_q;
    logic [16:0]          s2Mod_q;
    logic [PHASE_W-1:0]   s2OldPhase_q;

    opId_t                opId_q, opId_d;
    alg_t                 alg_q, alg_d;
    logic                 noteOn_q, noteOn_d;
    logic [16:0]          phase_q, phase_d;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= ST_CLEAR;
            clearCount_q <= '0;
        end else begin
            state_q      <= state_d;
            clearCount_q <= clearCount_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clearCount_d = clearCount_q;
        clearing     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clearing     = 1'b1;
                clearCount_d = clearCount_q + opId_t'(1);
                if (clearCount_q == LAST_ID) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign ready      = (state_q == ST_RUN);
    assign clearWrite = clearing & ~i_Reset;

    // Reads happen before writes at the same edge, so a visit coinciding with a step write sees the old step.
    always_ff @(posedge i_Clock) begin
        if (clearWrite) begin
            accRam[clearCount_q]  <= '0;
            stepRam[clearCount_q] <= '0;
            histRam[clearCount_q] <= 1'b0;
        end else begin
            if (s1Valid_q && !i_Reset) begin
                accRam[s1Id_q]  <= accWrData;
                histRam[s1Id_q] <= s1NoteOn_q;
            end
            if (ready && !i_Reset && i_PhaseStepWriteEnable) begin
                stepRam[i_PhaseStepWriteAddr] <= i_PhaseStepWriteData;
            end
        end
        s1Acc_q  <= accRam[i_VoiceOperator];
        s1Step_q <= stepRam[i_VoiceOperator];
        s1Hist_q <= histRam[i_VoiceOperator];
    end

    always_comb begin
        s1Valid_d  = ready;
        s1Id_d     = '0;
        s1Alg_d    = '0;
        s1NoteOn_d = 1'b0;
        s1Mod_d    = '0;
        if (ready) begin
            s1Id_d     = i_VoiceOperator;
            s1Alg_d    = i_AlgorithmWord;
            s1NoteOn_d = i_NoteOn;
            s1Mod_d    = $unsigned(i_ModulationPhase);
        end
    end

    // A rising gate restarts the accumulator; the emitted phase is always the pre-increment value.
    assign keyOn     = s1NoteOn_q & ~s1Hist_q;
    assign accSum    = s1Acc_q + s1Step_q;
    assign accWrData = keyOn ? '0 : accSum;
    assign oldPhase  = keyOn ? '0 : s1Acc_q[ACC_WIDTH-1 -: PHASE_W];

    always_comb begin
        opId_d   = '0;
        alg_d    = '0;
        noteOn_d = 1'b0;
        phase_d  = '0;
        if (s2Valid_q) begin
            opId_d   = s2Id_q;
            alg_d    = s2Alg_q;
            noteOn_d = s2NoteOn_q;
            phase_d  = {1'b0, s2OldPhase_q} + s2Mod_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s1Valid_q    <= 1'b0;
            s1Id_q       <= '0;
            s1Alg_q      <= '0;
            s1NoteOn_q   <= 1'b0;
            s1Mod_q      <= '0;
            s2Valid_q    <= 1'b0;
            s2Id_q       <= '0;
            s2Alg_q      <= '0;
            s2NoteOn_q   <= 1'b0;
            s2Mod_q      <= '0;
            s2OldPhase_q <= '0;
            opId_q       <= '0;
            alg_q        <= '0;
            noteOn_q     <= 1'b0;
            phase_q      <= '0;
        end else begin
            s1Valid_q    <= s1Valid_d;
            s1Id_q       <= s1Id_d;
            s1Alg_q      <= s1Alg_d;
            s1NoteOn_q   <= s1NoteOn_d;
            s1Mod_q      <= s1Mod_d;
            s2Valid_q    <= s1Valid_q;
            s2Id_q       <= s1Id_q;
            s2Alg_q      <= s1Alg_q;
            s2NoteOn_q   <= s1NoteOn_q;
            s2Mod_q      <= s1Mod_q;
            s2OldPhase_q <= oldPhase;
            opId_q       <= opId_d;
            alg_q        <= alg_d;
            noteOn_q     <= noteOn_d;
            phase_q      <= phase_d;
        end
    end

    assign o_VoiceOperator = opId_q;
    assign o_AlgorithmWord = alg_q;
    assign o_NoteOn        = noteOn_q;
    assign o_Phase         = $signed(phase_q);
    assign o_Ready         = ready;

endmodule
